// File: rtl/booth_controller.sv
// rtl/booth_controller.sv - radix-2 Booth multiplier sequencing FSM
module booth_controller #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q0,
  input  logic       qm1,
  output logic [1:0] a_ctrl,
  output logic [1:0] q_ctrl,
  output logic [1:0] m_ctrl,
  output logic       alu_sub,
  output logic       qm1_clr,
  output logic       qm1_ld,
  output logic       busy,
  output logic       done
);

  // Register control encoding shared with the A/Q/M register blocks.
  localparam logic [1:0] CTRL_LOAD  = 2'b00;
  localparam logic [1:0] CTRL_RESET = 2'b01;
  localparam logic [1:0] CTRL_SHIFT = 2'b10;
  localparam logic [1:0] CTRL_HOLD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_EVAL  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and iteration counter; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; the last SHIFT is the one that sees cnt==1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        cnt_d   = CNT_INIT;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d   = cnt_q - CNT_ONE;
        state_d = (cnt_q == CNT_ONE) ? S_DONE : S_EVAL;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath controls are pure state decode; q0/qm1 only matter in EVAL.
  always_comb begin
    a_ctrl  = CTRL_HOLD;
    q_ctrl  = CTRL_HOLD;
    m_ctrl  = CTRL_HOLD;
    alu_sub = 1'b0;
    qm1_clr = 1'b0;
    qm1_ld  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_INIT: begin
        a_ctrl  = CTRL_RESET;
        q_ctrl  = CTRL_LOAD;
        m_ctrl  = CTRL_LOAD;
        qm1_clr = 1'b1;
        busy    = 1'b1;
      end
      S_EVAL: begin
        busy = 1'b1;
        case ({q0, qm1})
          2'b01: begin
            a_ctrl = CTRL_LOAD;
          end
          2'b10: begin
            a_ctrl  = CTRL_LOAD;
            alu_sub = 1'b1;
          end
          default: begin
            a_ctrl = CTRL_HOLD;
          end
        endcase
      end
      S_SHIFT: begin
        a_ctrl = CTRL_SHIFT;
        q_ctrl = CTRL_SHIFT;
        qm1_ld = 1'b1;
        busy   = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        a_ctrl = CTRL_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// tb/tb_booth_controller.sv - directed bench for booth_controller
module tb_booth_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, q0, qm1;
  logic [1:0] a_ctrl, q_ctrl, m_ctrl;
  logic       alu_sub, qm1_clr, qm1_ld, busy, done;

  logic       start8, q0_8, qm1_8;
  logic [1:0] a_ctrl8, q_ctrl8, m_ctrl8;
  logic       alu_sub8, qm1_clr8, qm1_ld8, busy8, done8;

  int total = 0;
  int bad   = 0;

  localparam logic [10:0] EXP_IDLE  = 11'b11_11_11_0_0_0_0_0;
  localparam logic [10:0] EXP_INIT  = 11'b01_00_00_0_1_0_1_0;
  localparam logic [10:0] EXP_SHIFT = 11'b10_10_11_0_0_1_1_0;
  localparam logic [10:0] EXP_DONE  = 11'b11_11_11_0_0_0_0_1;

  booth_controller #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst), .start(start), .q0(q0), .qm1(qm1),
    .a_ctrl(a_ctrl), .q_ctrl(q_ctrl), .m_ctrl(m_ctrl), .alu_sub(alu_sub),
    .qm1_clr(qm1_clr), .qm1_ld(qm1_ld), .busy(busy), .done(done)
  );

  booth_controller #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .q0(q0_8), .qm1(qm1_8),
    .a_ctrl(a_ctrl8), .q_ctrl(q_ctrl8), .m_ctrl(m_ctrl8), .alu_sub(alu_sub8),
    .qm1_clr(qm1_clr8), .qm1_ld(qm1_ld8), .busy(busy8), .done(done8)
  );

  wire [10:0] outs4 = {a_ctrl, q_ctrl, m_ctrl, alu_sub, qm1_clr, qm1_ld, busy, done};
  wire [10:0] outs8 = {a_ctrl8, q_ctrl8, m_ctrl8, alu_sub8, qm1_clr8, qm1_ld8, busy8, done8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge with dut4 in IDLE. pat holds {q0,qm1} per
  // iteration (iteration 0 in bits 1:0); exp holds {a_ctrl,alu_sub} per
  // iteration (iteration 0 in bits 2:0). start is raised for E0, for edge
  // pulse_e, and for every edge when hold is set.
  task automatic run4(input string tag, input logic [7:0] pat, input logic [11:0] exp,
                      input int pulse_e, input bit hold);
    int         i;
    logic [2:0] ev;
    start = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      @(negedge clk);
      if (e == 0) begin
        check($sformatf("%s init", tag), outs4, EXP_INIT);
        {q0, qm1} = pat[1:0];
      end else if (e <= 8 && (e % 2) == 1) begin
        i  = (e - 1) / 2;
        ev = exp[3*i +: 3];
        check($sformatf("%s eval%0d", tag, i), outs4, {ev[2:1], 2'b11, 2'b11, ev[0], 4'b0010});
        {q0, qm1} = 2'bxx;
      end else if (e <= 8) begin
        i = e / 2;
        check($sformatf("%s shift%0d", tag, i - 1), outs4, EXP_SHIFT);
        if (i < 4) {q0, qm1} = pat[2*i +: 2];
      end else if (e == 9) begin
        check($sformatf("%s done", tag), outs4, EXP_DONE);
      end else begin
        check($sformatf("%s idle after done", tag), outs4, EXP_IDLE);
      end
      start = hold || ((e + 1) == pulse_e);
    end
  endtask

  initial begin
    int shifts, dones, done_e, busy_cnt, sub_cnt, clr_cnt, ld_cnt, mload_cnt;
    rst = 1'b0; start = 1'b0; q0 = 1'b0; qm1 = 1'b0;
    start8 = 1'b0; q0_8 = 1'b0; qm1_8 = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("reset4 async", outs4, EXP_IDLE);
    check("reset8 async", outs8, EXP_IDLE);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("idle hold %0d", k), outs4, EXP_IDLE);
    end

    // Pairs 10,01,00,11 -> {a,sub} 00/1, 00/0, 11/0, 11/0.
    run4("seq1", 8'b11_00_01_10, 12'b110_110_000_001, -1, 1'b0);

    // Pairs 11,00,01,10 with an ignored start pulse at E5.
    run4("seq2", 8'b10_01_00_11, 12'b001_000_110_110, 5, 1'b0);

    // Start held high: the next INIT follows E11.
    run4("hold", 8'b01_10_00_01, 12'b000_001_110_000, -1, 1'b1);
    @(negedge clk);
    check("hold reinit E11", outs4, EXP_INIT);
    start = 1'b0;
    {q0, qm1} = 2'b10;
    @(negedge clk);
    check("abort eval0", outs4, 11'b00_11_11_1_0_0_1_0);
    {q0, qm1} = 2'b01;
    @(negedge clk);
    check("abort shift0", outs4, EXP_SHIFT);
    @(negedge clk);
    {q0, qm1} = 2'b00;
    @(negedge clk);
    check("abort shift1", outs4, EXP_SHIFT);
    #2 rst = 1'b1;
    #1;
    check("abort async idle", outs4, EXP_IDLE);
    @(negedge clk);
    rst = 1'b0;
    check("abort still idle", outs4, EXP_IDLE);

    // Fresh run after the abort: pairs 01,01,10,00.
    run4("fresh", 8'b00_10_01_01, 12'b110_001_000_000, -1, 1'b0);

    // WIDTH=8 instance, every EVAL sees {q0,qm1}=10.
    {q0_8, qm1_8} = 2'b10;
    shifts = 0; dones = 0; done_e = -1; busy_cnt = 0;
    sub_cnt = 0; clr_cnt = 0; ld_cnt = 0; mload_cnt = 0;
    start8 = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (q_ctrl8 == 2'b10) shifts++;
      if (busy8) busy_cnt++;
      if (alu_sub8) sub_cnt++;
      if (qm1_clr8) clr_cnt++;
      if (qm1_ld8) ld_cnt++;
      if (m_ctrl8 == 2'b00 && a_ctrl8 == 2'b01) mload_cnt++;
      if (done8) begin
        dones++;
        done_e = e;
      end
    end
    check("w8 shifts", shifts, 8);
    check("w8 done count", dones, 1);
    check("w8 done edge", done_e, 17);
    check("w8 busy cycles", busy_cnt, 17);
    check("w8 sub cycles", sub_cnt, 8);
    check("w8 qm1_clr cycles", clr_cnt, 1);
    check("w8 qm1_ld cycles", ld_cnt, 8);
    check("w8 init cycles", mload_cnt, 1);
    check("w8 final idle", outs8, EXP_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_controller.md
Name: booth_controller

Overview:
Sequencing FSM for the radix-2 Booth multiplier datapath. Drives the 2-bit ctrl inputs of the A, Q and M registers, the add/subtract select of the A-path adder, and the Q-1 flip-flop. It examines Q[0] and Q-1 each iteration and runs WIDTH add/sub-then-shift iterations. It reports completion with a one-cycle done pulse.

Parameters:
WIDTH, 4, operand width in bits; equals the number of Booth iterations.
CNT_W, 3, iteration counter width; must be at least clog2(WIDTH+1).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  begin a multiply; sampled only in IDLE
q0  input  1  current Q register LSB
qm1  input  1  current Q-1 flip-flop value
a_ctrl  output  2  A register control
q_ctrl  output  2  Q register control
m_ctrl  output  2  M register control
alu_sub  output  1  1 = A minus M, 0 = A plus M (adder result feeds A load)
qm1_clr  output  1  synchronous clear of the Q-1 flip-flop
qm1_ld  output  1  Q-1 flip-flop loads q0 on this edge
busy  output  1  high from INIT through the last SHIFT
done  output  1  one-cycle completion pulse

Behaviour:
- Register ctrl encoding is shared with the register blocks: LOAD=00, RESET=01, SHIFT=10, HOLD=11.
- States: IDLE, INIT, EVAL, SHIFT, DONE. The state register and the iteration counter cnt are the only flops.
- rst=1 takes effect immediately and asynchronously:
  - state=IDLE, cnt=0.
  - Outputs take their IDLE values: all ctrl=HOLD, alu_sub=0, qm1_clr=0, qm1_ld=0, busy=0, done=0.
- IDLE: all ctrl=HOLD, busy=0. start=1 on a rising edge moves to INIT. Otherwise stay in IDLE.
- INIT (1 cycle): a_ctrl=RESET, q_ctrl=LOAD, m_ctrl=LOAD, qm1_clr=1, busy=1. Edge loads cnt=WIDTH and moves to EVAL.
- EVAL (1 cycle): q_ctrl=HOLD, m_ctrl=HOLD, busy=1. a_ctrl and alu_sub decode combinationally from {q0,qm1}:
  - 01: a_ctrl=LOAD, alu_sub=0.
  - 10: a_ctrl=LOAD, alu_sub=1.
  - 00 or 11: a_ctrl=HOLD, alu_sub=0.
  - Edge moves to SHIFT.
- SHIFT (1 cycle): a_ctrl=SHIFT, q_ctrl=SHIFT, m_ctrl=HOLD, qm1_ld=1, busy=1.
  - Edge decrements cnt.
  - If cnt==1 before the decrement, go to DONE; otherwise go to EVAL.
- DONE (1 cycle): all ctrl=HOLD, done=1, busy=0. Edge goes to IDLE unconditionally.
- alu_sub is 0 in every state except EVAL with {q0,qm1}=10. qm1_clr and qm1_ld are never high together.
- Latency: call E0 the edge that samples start in IDLE.
  - INIT follows E0.
  - Iteration i (0..WIDTH-1): EVAL follows E(1+2i), SHIFT follows E(2+2i).
  - DONE follows E(2*WIDTH+1); IDLE follows E(2*WIDTH+2).
  - For WIDTH=4: done is high between E9 and E10.
- start outside IDLE (INIT, EVAL, SHIFT, DONE) is ignored; there is no abort input.
- If start stays high continuously, a new operation begins on the first edge back in IDLE, i.e. E(2*WIDTH+3). There is no back-to-back start from DONE.
- q0/qm1 are used only in EVAL and may be X in all other states without affecting outputs.
- Reset mid-operation discards all progress. The next start runs a full fresh sequence.

Test Plan:
- Reset: assert rst with no clk edges → immediately state IDLE, a/q/m_ctrl=11, busy=0, done=0. Deassert; hold start=0 for 5 cycles → outputs unchanged.
- Full sequence, WIDTH=4: pulse start one cycle; drive {q0,qm1}=10,01,00,11 in successive EVALs →
  - INIT: a/q/m_ctrl=01/00/00, qm1_clr=1.
  - EVAL a_ctrl/alu_sub: 00/1, 00/0, 11/0, 11/0.
  - Each SHIFT: a_ctrl=q_ctrl=10, qm1_ld=1.
  - done=1 for exactly one cycle after E9; busy=1 after E0 through E8.
- Start ignored while busy: pulse start again after E4 → no change to sequence, done still after E9 only. Hold start high throughout → second INIT follows E11.
- Asynchronous reset mid-op: assert rst between clk edges during the second SHIFT → outputs go to IDLE values immediately. Release; pulse start → INIT after that edge and done 9 edges later.
- Parameter WIDTH=8 (CNT_W=4): single start → exactly 8 SHIFT cycles, done after E17.
- Decode exhaustive: in EVAL sweep {q0,qm1} over all 4 values across runs; check alu_sub=0 in all non-EVAL cycles → matches the decode table.
